// File: rtl/rvfi_seq_pkg.sv
// rvfi_seq_pkg: shared state type, order width and channel-select helper for the check sequencer
package rvfi_seq_pkg;
  localparam int ORDER_W = 64;
  typedef enum logic [1:0] {IDLE, ARMED, DONE, TIMEOUT} state_t;
  function automatic int lowest_set(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 63; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/rvfi_order_tracker.sv
// rvfi_order_tracker: sticky flag for retire-order gaps or non-contiguous valid channels
module rvfi_order_tracker
  import rvfi_seq_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [ORDER_W*NRET-1:0] rvfi_order,
  output logic                    order_err
);
  logic [ORDER_W-1:0] next_order, base, step;
  logic order_valid, bad;
  // Until the first retire is seen, channel 0 seeds the expected order.
  always_comb begin
    base = order_valid ? next_order : rvfi_order[ORDER_W-1:0];
    step = '0;
    bad = 1'b0;
    for (int j = 0; j < NRET; j++) begin
      step = step + ORDER_W'(rvfi_valid[j]);
      if (rvfi_valid[j] && rvfi_order[ORDER_W*j +: ORDER_W] != base + ORDER_W'(j)) bad = 1'b1;
    end
    for (int j = 1; j < NRET; j++)
      if (rvfi_valid[j] && !rvfi_valid[j-1]) bad = 1'b1;
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      next_order <= '0;
      order_valid <= 1'b0;
      order_err <= 1'b0;
    end else if (|rvfi_valid) begin
      next_order <= base + step;
      order_valid <= 1'b1;
      order_err <= order_err | bad;
    end
endmodule

// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: fires one check pulse when the target order retires on an eligible channel
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int NRET = 1,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W = 8,
  localparam int CH_W = NRET > 1 ? $clog2(NRET) : 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [ORDER_W-1:0]      target_order,
  input  logic [NRET-1:0]         chan_mask,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [ORDER_W*NRET-1:0] rvfi_order,
  output logic                    check,
  output logic [CH_W-1:0]         check_channel,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    order_err
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [ORDER_W-1:0] target;
  logic [NRET-1:0] match;
  logic last;
  for (genvar i = 0; i < NRET; i++)
    assign match[i] = rvfi_valid[i] & chan_mask[i] & (rvfi_order[ORDER_W*i +: ORDER_W] == target);
  assign last = cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= IDLE;
      cycle_cnt <= '0;
      target <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) target <= target_order;
      cycle_cnt <= state == ARMED ? cycle_cnt + CNT_W'(1) : '0;
    end
  // A match in the last allowed cycle takes priority over the timeout.
  always_comb
    case (state)
      IDLE:    state_nxt = start ? ARMED : IDLE;
      ARMED:   state_nxt = |match ? DONE : last ? TIMEOUT : ARMED;
      default: state_nxt = state;
    endcase
  always_comb begin
    check = resetn && state == ARMED && |match;
    check_channel = check ? CH_W'(lowest_set(ORDER_W'(match))) : '0;
    busy = state == ARMED;
    done = state == DONE;
    timeout = state == TIMEOUT;
  end
  rvfi_order_tracker #(.NRET(NRET)) u_tracker (
    .clock      (clock),
    .resetn     (resetn),
    .rvfi_valid (rvfi_valid),
    .rvfi_order (rvfi_order),
    .order_err  (order_err)
  );
endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// tb_rvfi_check_sequencer: vector table, directed corner sequences and random run against a reference model
module tb_rvfi_check_sequencer;
  localparam int NRET = 2;
  localparam int TO = 32;
  logic clock = 1'b0;
  logic resetn, start;
  logic [63:0] target_order;
  logic [1:0] chan_mask, rvfi_valid;
  logic [127:0] rvfi_order;
  logic check, check_channel, busy, done, timeout, order_err;
  int n_cmp = 0;
  int n_bad = 0;
  logic m_arm, m_done, m_to, m_seed, m_err;
  int m_cnt;
  logic [63:0] m_tgt, m_next;
  typedef struct {
    logic rn, st;
    logic [63:0] tg;
    logic [1:0] mk, vl;
    logic [63:0] o0, o1;
    logic e_chk, e_ch, e_busy, e_done, e_to, e_err;
  } vec_t;
  vec_t tbl[8];
  always #5 clock = ~clock;
  rvfi_check_sequencer #(.NRET(NRET), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .start         (start),
    .target_order  (target_order),
    .chan_mask     (chan_mask),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .check         (check),
    .check_channel (check_channel),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .order_err     (order_err)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic drive(input logic rn, st, input logic [63:0] tg, input logic [1:0] mk, vl,
                       input logic [63:0] o0, o1);
    resetn = rn;
    start = st;
    target_order = tg;
    chan_mask = mk;
    rvfi_valid = vl;
    rvfi_order = {o1, o0};
  endtask
  function automatic logic [1:0] m_match();
    return {rvfi_valid[1] & chan_mask[1] & (rvfi_order[127:64] == m_tgt),
            rvfi_valid[0] & chan_mask[0] & (rvfi_order[63:0] == m_tgt)};
  endfunction
  task automatic model_cmp();
    logic [1:0] mm;
    logic e_chk;
    mm = m_match();
    e_chk = resetn && m_arm && |mm;
    chk("check", check, e_chk);
    chk("check_channel", check_channel, e_chk && !mm[0]);
    chk("busy", busy, m_arm);
    chk("done", done, m_done);
    chk("timeout", timeout, m_to);
    chk("order_err", order_err, m_err);
  endtask
  task automatic model_step();
    logic [1:0] mm;
    logic [63:0] base, o0, o1;
    mm = m_match();
    o0 = rvfi_order[63:0];
    o1 = rvfi_order[127:64];
    if (!resetn) begin
      m_arm = 0; m_done = 0; m_to = 0; m_seed = 0; m_err = 0;
      m_cnt = 0; m_tgt = 0; m_next = 0;
    end else begin
      if (m_arm) begin
        if (|mm) begin m_arm = 0; m_done = 1; end
        else if (m_cnt == TO - 1) begin m_arm = 0; m_to = 1; end
        else m_cnt++;
      end else if (!m_done && !m_to && start) begin
        m_arm = 1; m_cnt = 0; m_tgt = target_order;
      end
      if (|rvfi_valid) begin
        base = m_seed ? m_next : o0;
        if (rvfi_valid == 2'b10) m_err = 1;
        if (rvfi_valid[0] && o0 != base) m_err = 1;
        if (rvfi_valid[1] && o1 != base + 64'd1) m_err = 1;
        m_next = base + (rvfi_valid == 2'b11 ? 64'd2 : 64'd1);
        m_seed = 1;
      end
    end
  endtask
  task automatic apply(input logic rn, st, input logic [63:0] tg, input logic [1:0] mk, vl,
                       input logic [63:0] o0, o1);
    @(negedge clock);
    drive(rn, st, tg, mk, vl, o0, o1);
    #1 model_cmp();
    @(posedge clock);
    #1 model_step();
  endtask
  initial begin
    drive(1'b0, 1'b0, 0, 2'b00, 2'b00, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1 model_step();
    tbl[0] = '{1'b0, 1'b0, 64'd0, 2'b11, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 64'd5, 2'b11, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 64'd0, 2'b11, 2'b01, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 64'd0, 2'b11, 2'b11, 64'd1, 64'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 64'd0, 2'b11, 2'b01, 64'd3, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 64'd0, 2'b11, 2'b11, 64'd4, 64'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 64'd0, 2'b11, 2'b01, 64'd6, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 64'd7, 2'b11, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive(tbl[i].rn, tbl[i].st, tbl[i].tg, tbl[i].mk, tbl[i].vl, tbl[i].o0, tbl[i].o1);
      #1;
      chk($sformatf("tbl%0d_check", i), check, tbl[i].e_chk);
      chk($sformatf("tbl%0d_channel", i), check_channel, tbl[i].e_ch);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_timeout", i), timeout, tbl[i].e_to);
      chk($sformatf("tbl%0d_order_err", i), order_err, tbl[i].e_err);
      @(posedge clock);
      #1 model_step();
    end
    // both channels carry the target: one pulse on channel 0, order error flagged
    apply(1'b0, 1'b0, 0, 2'b11, 2'b00, 0, 0);
    apply(1'b1, 1'b1, 7, 2'b11, 2'b01, 7, 0);
    apply(1'b1, 1'b0, 0, 2'b11, 2'b11, 7, 7);
    chk("dual_done", done, 1'b1);
    chk("dual_err", order_err, 1'b1);
    // target only on a masked-off channel: timeout after exactly TO armed cycles
    apply(1'b0, 1'b0, 0, 2'b01, 2'b00, 0, 0);
    apply(1'b1, 1'b1, 9, 2'b01, 2'b01, 7, 0);
    apply(1'b1, 1'b0, 0, 2'b01, 2'b11, 8, 9);
    for (int i = 0; i < TO - 2; i++) apply(1'b1, 1'b0, 0, 2'b01, 2'b00, 0, 0);
    chk("to_busy_before", busy, 1'b1);
    chk("to_flag_before", timeout, 1'b0);
    apply(1'b1, 1'b0, 0, 2'b01, 2'b00, 0, 0);
    chk("to_flag", timeout, 1'b1);
    chk("to_busy_after", busy, 1'b0);
    // order gap 0,1,3 sets a sticky error cleared only by reset
    apply(1'b0, 1'b0, 0, 2'b11, 2'b00, 0, 0);
    apply(1'b1, 1'b0, 0, 2'b11, 2'b01, 0, 0);
    apply(1'b1, 1'b0, 0, 2'b11, 2'b01, 1, 0);
    chk("gap_err_before", order_err, 1'b0);
    apply(1'b1, 1'b0, 0, 2'b11, 2'b01, 3, 0);
    chk("gap_err_set", order_err, 1'b1);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 0, 2'b11, 2'b01, 64'(4 + i), 0);
    chk("gap_err_sticky", order_err, 1'b1);
    apply(1'b0, 1'b0, 0, 2'b11, 2'b00, 0, 0);
    chk("gap_err_cleared", order_err, 1'b0);
    // reset lands in the cycle a match arrives
    apply(1'b1, 1'b1, 4, 2'b11, 2'b00, 0, 0);
    apply(1'b0, 1'b0, 0, 2'b11, 2'b01, 4, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_err", order_err, 1'b0);
    // order wrap-around with target 0
    apply(1'b1, 1'b1, 0, 2'b01, 2'b00, 0, 0);
    apply(1'b1, 1'b0, 0, 2'b01, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    apply(1'b1, 1'b0, 0, 2'b01, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    apply(1'b1, 1'b0, 0, 2'b01, 2'b01, 0, 0);
    chk("wrap_done", done, 1'b1);
    chk("wrap_err", order_err, 1'b0);
    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      logic rn, st;
      logic [1:0] mk, vl;
      logic [63:0] base, tg;
      rn = $urandom_range(0, 39) != 0;
      if ((m_done || m_to) && $urandom_range(0, 3) == 0) rn = 1'b0;
      st = $urandom_range(0, 3) == 0;
      mk = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 3: vl = 2'b00;
        1: vl = 2'b01;
        default: vl = 2'b11;
      endcase
      base = m_seed ? m_next : 64'($urandom_range(0, 100));
      if ($urandom_range(0, 59) == 0) base = base + 64'($urandom_range(1, 3));
      tg = (m_seed ? m_next : 64'd0) + 64'($urandom_range(0, 8));
      apply(rn, st, tg, mk, vl, base, base + 64'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rvfi_check_sequencer.md
Name: rvfi_check_sequencer

Overview:
- Schedules the single `check` pulse that drives one rvfi channel checker (PC forward/backward, register, causal checks) in a formal or simulation harness.
- Arms on a start request for a target instruction order and watches all NRET retire channels.
- Fires `check` in exactly the cycle the target instruction retires on an eligible channel, and reports which channel it was.
- Enforces a cycle timeout and tracks retire-order continuity so harness misconfiguration is flagged rather than silently passing.

Parameters:
- NRET, 1, number of retire channels.
- TIMEOUT_CYCLES, 32, maximum cycles spent in ARMED before TIMEOUT; must be at least 1.
- CNT_W, 8, width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  single clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  arm request, sampled only in IDLE.
- target_order  in  64  order to check, latched on an accepted start.
- chan_mask  in  NRET  eligible channels; sampled live, not latched.
- rvfi_valid  in  NRET  retire valid per channel.
- rvfi_order  in  64*NRET  retire order; channel i occupies [64*i +: 64].
- check  out  1  Mealy pulse into the checker.
- check_channel  out  $clog2(NRET) (minimum 1)  channel matched this cycle; 0 when check is low.
- busy  out  1  high in ARMED.
- done  out  1  high in DONE.
- timeout  out  1  high in TIMEOUT.
- order_err  out  1  sticky retire-order discontinuity.

Behaviour:
- Reset (resetn low at a clock edge):
  - state=IDLE, cycle_cnt=0, latched target=0, next_order=0, order_valid=0, order_err=0.
  - check is gated low whenever resetn is low, including the cycle reset is applied mid-ARMED.
- IDLE:
  - start=1 latches target_order, clears cycle_cnt, and moves to ARMED.
  - check is never asserted in IDLE, even if a matching retire is present in the start cycle.
- ARMED:
  - match_i = rvfi_valid[i] & chan_mask[i] & (order_i == target).
  - On any match, check=1 combinationally in the same cycle and check_channel = lowest matching i.
  - After a match, the next state is DONE.
  - If there is no match and cycle_cnt == TIMEOUT_CYCLES-1, the next state is TIMEOUT.
  - Otherwise cycle_cnt increments.
  - A match in the final timeout cycle wins; the state goes to DONE.
- DONE and TIMEOUT are terminal until reset. start is ignored and check stays 0.
- Outputs busy, done and timeout are decoded directly from the state register.
- Order tracker (runs in every state while out of reset):
  - Let k = popcount(rvfi_valid) in the current cycle.
  - The valid channels must be contiguous from channel 0.
  - Channel j must carry order next_order+j.
  - The first cycle with k>0 after reset seeds next_order from channel 0's order and skips the comparison for channel 0 only.
  - After any cycle with k>0, next_order += k, using 64-bit wrap-around.
  - Any violation sets order_err, which stays set until reset.
  - Cycles with k=0 change nothing.
- Order wrap: a target of 2^64-1 is matched literally. next_order wraps to 0 with no error.
- Simultaneous events: when several channels match in one cycle, only the lowest index is reported and only one check pulse is issued.
- Latency: check is zero-cycle from rvfi_valid; done is visible the cycle after check.

Decomposition:
- Package rvfi_seq_pkg holds:
  - the state enum {IDLE, ARMED, DONE, TIMEOUT}, 2 bits;
  - the ORDER_W=64 constant;
  - a function for the lowest-set-bit index.
- One sub-module, rvfi_order_tracker, contains the next_order, order_valid and order_err logic, instantiated once.

Test Plan:
- NRET=2: start with target=5; order 5 retires on channel 1 at cycle 3 with mask=11 → check=1 and check_channel=1 in that cycle only; done=1 from cycle 4.
- Both channels match order 7 in the same cycle (harness misconfiguration), mask=11 → single check pulse with check_channel=0; order_err=1.
- mask=01 and target=9 retires only on channel 1 → check stays 0; timeout=1 after exactly 32 ARMED cycles.
- Orders 0,1 then 3 on channel 0 → order_err set at the order-3 cycle and stays set; it clears only after resetn=0.
- resetn driven low in the cycle a match arrives in ARMED → check=0; the next state is IDLE and all outputs are 0.
- Orders run 2^64-2, 2^64-1, 0 on channel 0 with target=0 → no order_err; check fires on the retire of order 0.
